// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/writeback path: load funct3 codes,
// load sequencer state encoding and the alignment rule.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } ld_state_e;

  // Halfwords need an even address, words need a 4-byte aligned address.
  // Undefined funct3 codes behave as LW, so they follow the word rule too.
  function automatic logic ld_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    case (f3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = lane[0];
      default:       mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select and sign/zero extension of a loaded word. Purely combinational
// so the store path can share it.
module load_extract
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the word (little-endian).
  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Extend according to load type; unknown codes pass the whole word.
  always_comb begin
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_wb_unit.sv
// Load/writeback sequencer: accepts one load, issues a single-word memory
// read, extracts the result and writes it back to the register file.
//
// state | meaning
// IDLE  | ready for a new load; misaligned loads are rejected here
// REQ   | mem_req high with a stable word address until mem_gnt
// WAIT  | request granted, waiting for mem_rvalid
// WB    | one-cycle register file write (suppressed for rd=0)
module load_wb_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_funct3,
  input  logic [4:0]        ld_rd,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_en,
  output logic              busy,
  output logic              misalign
);

  ld_state_e         state_q,    state_d;
  logic [2:0]        funct3_q,   funct3_d;
  logic [4:0]        rd_q,       rd_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [31:0]       result_q,   result_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       extract_res;

  // mem_rdata only reaches wb_data through result_q.
  load_extract u_load_extract (
    .funct3 (funct3_q),
    .lane   (addr_q[1:0]),
    .word   (mem_rdata),
    .result (extract_res)
  );

  // Next-state and capture logic for the load sequence.
  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    result_d   = result_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          funct3_d = ld_funct3;
          rd_d     = ld_rd;
          addr_d   = ld_addr;
          if (ld_misaligned(ld_funct3, ld_addr[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A response arriving alongside the grant is not a real response.
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          result_d = extract_res;
          state_d  = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-load registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      addr_q     <= '0;
      result_q   <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs are flops or decodes of the state register only.
  always_comb begin
    ld_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    mem_req  = (state_q == REQ);
    mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    wb_en    = (state_q == WB) && (rd_q != 5'd0);
    wb_rd    = rd_q;
    wb_data  = result_q;
    misalign = misalign_q;
  end

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed bench for load_wb_unit: table of load vectors plus hand-written
// sequences for stalls, misalignment, rd=0 and reset during a load.
module tb_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic [31:0] ld_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic        busy;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  load_wb_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_funct3  (ld_funct3),
    .ld_rd      (ld_rd),
    .ld_addr    (ld_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_en      (wb_en),
    .busy       (busy),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ld_ready"}, 32'(ld_ready), 32'd1);
    chk({tag, " mem_req"},  32'(mem_req),  32'd0);
    chk({tag, " mem_addr"}, mem_addr,      32'd0);
    chk({tag, " wb_en"},    32'(wb_en),    32'd0);
    chk({tag, " wb_rd"},    32'(wb_rd),    32'd0);
    chk({tag, " wb_data"},  wb_data,       32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " misalign"}, 32'(misalign), 32'd0);
  endtask

  // Full load with gnt_dly cycles before grant and rv_dly cycles between
  // grant and response. stray_rv raises mem_rvalid in the grant cycle with
  // junk data, which must be ignored.
  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp,
                         input int gnt_dly, input int rv_dly, input logic exp_en,
                         input logic stray_rv);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    @(negedge clk);
    chk("accept ld_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_funct3 = f3; ld_rd = rd; ld_addr = addr;
    @(negedge clk);
    ld_valid = 1'b0; ld_addr = 32'hffff_ffff; ld_rd = 5'd31; ld_funct3 = 3'b000;
    for (int i = 0; i < gnt_dly; i++) begin
      chk("stall mem_req",  32'(mem_req),  32'd1);
      chk("stall mem_addr", mem_addr,      waddr);
      chk("stall busy",     32'(busy),     32'd1);
      chk("stall ld_ready", 32'(ld_ready), 32'd0);
      chk("stall wb_en",    32'(wb_en),    32'd0);
      @(negedge clk);
    end
    chk("req mem_req",  32'(mem_req),  32'd1);
    chk("req mem_addr", mem_addr,      waddr);
    chk("req ld_ready", 32'(ld_ready), 32'd0);
    mem_gnt = 1'b1;
    if (stray_rv) begin mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5a5a_5a5a;
    for (int i = 0; i < rv_dly; i++) begin
      chk("wait mem_req",  32'(mem_req),  32'd0);
      chk("wait busy",     32'(busy),     32'd1);
      chk("wait ld_ready", 32'(ld_ready), 32'd0);
      chk("wait wb_en",    32'(wb_en),    32'd0);
      @(negedge clk);
    end
    chk("rsp mem_req", 32'(mem_req), 32'd0);
    chk("rsp wb_en",   32'(wb_en),   32'd0);
    mem_rvalid = 1'b1; mem_rdata = word;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h5a5a_5a5a;
    chk("wb wb_en",   32'(wb_en), 32'(exp_en));
    chk("wb wb_rd",   32'(wb_rd), 32'(rd));
    chk("wb wb_data", wb_data,    exp);
    chk("wb busy",    32'(busy),  32'd1);
    @(negedge clk);
    chk("post wb_en",    32'(wb_en),    32'd0);
    chk("post ld_ready", 32'(ld_ready), 32'd1);
    chk("post busy",     32'(busy),     32'd0);
  endtask

  task automatic do_misalign(input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    ld_valid = 1'b1; ld_funct3 = f3; ld_rd = 5'd7; ld_addr = addr;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("mis pulse",    32'(misalign), 32'd1);
    chk("mis mem_req",  32'(mem_req),  32'd0);
    chk("mis ld_ready", 32'(ld_ready), 32'd1);
    chk("mis busy",     32'(busy),     32'd0);
    @(negedge clk);
    chk("mis end pulse", 32'(misalign), 32'd0);
    chk("mis end req",   32'(mem_req),  32'd0);
    chk("mis end wb_en", 32'(wb_en),    32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 5'd5,  32'h100, 32'hdeadbeef, 32'hdeadbeef};
    vecs[1]  = '{3'b000, 5'd1,  32'h103, 32'hdeadbeef, 32'hffffffde};
    vecs[2]  = '{3'b100, 5'd2,  32'h101, 32'hdeadbeef, 32'h000000be};
    vecs[3]  = '{3'b001, 5'd3,  32'h102, 32'hdeadbeef, 32'hffffdead};
    vecs[4]  = '{3'b101, 5'd4,  32'h100, 32'hdeadbeef, 32'h0000beef};
    vecs[5]  = '{3'b000, 5'd6,  32'h100, 32'hdeadbeef, 32'hffffffef};
    vecs[6]  = '{3'b100, 5'd7,  32'h103, 32'hdeadbeef, 32'h000000de};
    vecs[7]  = '{3'b101, 5'd8,  32'h102, 32'hdeadbeef, 32'h0000dead};
    vecs[8]  = '{3'b001, 5'd9,  32'h100, 32'hdeadbeef, 32'hffffbeef};
    vecs[9]  = '{3'b000, 5'd10, 32'h202, 32'h12345678, 32'h00000034};
    vecs[10] = '{3'b001, 5'd11, 32'h200, 32'h00007fff, 32'h00007fff};
    vecs[11] = '{3'b000, 5'd12, 32'h301, 32'h00008000, 32'hffffff80};
    vecs[12] = '{3'b011, 5'd13, 32'h104, 32'hcafef00d, 32'hcafef00d};
    vecs[13] = '{3'b110, 5'd14, 32'h108, 32'h80000001, 32'h80000001};
    vecs[14] = '{3'b111, 5'd15, 32'h10c, 32'h0000ff00, 32'h0000ff00};
    vecs[15] = '{3'b101, 5'd31, 32'hfffffffe, 32'h9abc1234, 32'h00009abc};

    rst = 1'b0;
    ld_valid = 1'b0; ld_funct3 = 3'b000; ld_rd = 5'd0; ld_addr = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    // Stray response while idle must not start anything.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("idle rvalid busy",  32'(busy),  32'd0);
    chk("idle rvalid wb_en", 32'(wb_en), 32'd0);

    for (int i = 0; i < NV; i++) begin
      do_load(vecs[i].f3, vecs[i].rd, vecs[i].addr, vecs[i].word, vecs[i].exp, 0, 0, 1'b1, 1'b0);
    end

    // Slow memory: grant after 3 cycles, response 2 cycles later, with a
    // response in the grant cycle that must be ignored.
    do_load(3'b010, 5'd20, 32'h440, 32'h0bad_f00d, 32'h0bad_f00d, 3, 2, 1'b1, 1'b1);

    do_misalign(3'b010, 32'h102);
    do_misalign(3'b001, 32'h101);
    do_misalign(3'b101, 32'h103);
    do_misalign(3'b011, 32'h105);

    // rd=0: access completes, no write enable.
    do_load(3'b010, 5'd0, 32'h100, 32'hdeadbeef, 32'hdeadbeef, 0, 1, 1'b0, 1'b0);

    // Reset while waiting for the response.
    @(negedge clk);
    ld_valid = 1'b1; ld_funct3 = 3'b010; ld_rd = 5'd9; ld_addr = 32'h500;
    @(negedge clk);
    ld_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_vals("async reset");
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_reset_vals("late rvalid");
    @(negedge clk);
    chk("late rvalid wb_en2", 32'(wb_en), 32'd0);

    do_load(3'b010, 5'd17, 32'h600, 32'h1357_9bdf, 32'h1357_9bdf, 0, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
